// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the pipelined KGP-RISC core.
// Per-operand forward selects for EX, load-use / multi-cycle stall requests
// for ID, and a single-entry scoreboard for the MUL/DIV unit.

// Per-operand slice: EX-stage forward select plus ID-stage hazard hits.
module fwd_lane #(
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0] ex_src,
    input  logic [AW-1:0] id_src,
    input  logic [AW-1:0] ex_mem_rd,
    input  logic          ex_mem_we,
    input  logic [AW-1:0] mem_wb_rd,
    input  logic          mem_wb_we,
    input  logic [AW-1:0] mc_dst,
    input  logic          mc_done,
    input  logic          mc_live,
    input  logic [AW-1:0] id_ex_rd,
    input  logic          id_ex_memread,
    input  logic          mc_issue,
    input  logic [AW-1:0] mc_rd,
    output logic [1:0]    sel,
    output logic          ld_hit,
    output logic          mc_hit
);
    // A destination only matches when it is actually written and, with
    // ZERO_REG set, it is not the hardwired zero register.
    function automatic logic hit(input logic we, input logic [AW-1:0] rd,
                                 input logic [AW-1:0] src);
        return we && (ZERO_REG == 0 || rd != '0) && (rd == src);
    endfunction

    // Forward priority: youngest producer (EX/MEM) first, then the MC
    // result bus, then MEM/WB.
    always_comb begin
        sel = 2'b00;
        if (hit(ex_mem_we, ex_mem_rd, ex_src))
            sel = 2'b10;
        else if (hit(mc_done, mc_dst, ex_src))
            sel = 2'b11;
        else if (hit(mem_wb_we, mem_wb_rd, ex_src))
            sel = 2'b01;
    end

    assign ld_hit = hit(id_ex_memread, id_ex_rd, id_src);
    assign mc_hit = hit(mc_live, mc_dst, id_src) | hit(mc_issue, mc_rd, id_src);
endmodule

module fwd_hazard_ctrl #(
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int MC_LAT   = 4,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC*AW-1:0]   id_ex_src,
    input  logic [AW-1:0]        ex_mem_rd,
    input  logic                 ex_mem_regwrite,
    input  logic [AW-1:0]        mem_wb_rd,
    input  logic                 mem_wb_regwrite,
    input  logic [NSRC*AW-1:0]   if_id_src,
    input  logic                 if_id_valid,
    input  logic                 if_id_mc,
    input  logic [AW-1:0]        id_ex_rd,
    input  logic                 id_ex_memread,
    input  logic                 mc_issue,
    input  logic [AW-1:0]        mc_rd,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 flush_id_ex,
    output logic                 mc_done,
    output logic [AW-1:0]        mc_done_rd,
    output logic [CNT_W-1:0]     stall_cycles
);
    localparam logic [3:0]       MC_INIT = 4'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic          mc_busy;
    logic [3:0]    mc_cnt;
    logic [AW-1:0] mc_dst;

    // mc_live: the MC result is still at least two cycles away, so a
    // consumer in ID could not yet be in EX on the done cycle.
    logic mc_live;
    assign mc_live    = mc_busy && (mc_cnt >= 4'd2);
    assign mc_done    = mc_busy && (mc_cnt == 4'd0);
    assign mc_done_rd = mc_dst;

    logic [NSRC-1:0][1:0] lane_sel;
    logic [NSRC-1:0]      ld_hit;
    logic [NSRC-1:0]      mc_hit;

    for (genvar i = 0; i < NSRC; i++) begin : g_lane
        fwd_lane #(.AW(AW), .ZERO_REG(ZERO_REG)) u_lane (
            .ex_src        (id_ex_src[i*AW +: AW]),
            .id_src        (if_id_src[i*AW +: AW]),
            .ex_mem_rd     (ex_mem_rd),
            .ex_mem_we     (ex_mem_regwrite),
            .mem_wb_rd     (mem_wb_rd),
            .mem_wb_we     (mem_wb_regwrite),
            .mc_dst        (mc_dst),
            .mc_done       (mc_done),
            .mc_live       (mc_live),
            .id_ex_rd      (id_ex_rd),
            .id_ex_memread (id_ex_memread),
            .mc_issue      (mc_issue),
            .mc_rd         (mc_rd),
            .sel           (lane_sel[i]),
            .ld_hit        (ld_hit[i]),
            .mc_hit        (mc_hit[i])
        );
    end

    assign fwd_sel = lane_sel;

    logic load_use, mc_raw, mc_struct;
    assign load_use  = if_id_valid && (|ld_hit);
    assign mc_raw    = if_id_valid && (|mc_hit);
    assign mc_struct = if_id_valid && if_id_mc && (mc_live || mc_issue);

    // Reset masks the stall immediately, even though hazards are combinational
    // from live pipeline inputs.
    assign stall       = !rst && (load_use || mc_raw || mc_struct);
    assign flush_id_ex = stall;

    // MC scoreboard: a new issue always reloads, even on the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_busy <= 1'b0;
            mc_cnt  <= 4'd0;
            mc_dst  <= '0;
        end else if (mc_issue) begin
            mc_busy <= 1'b1;
            mc_cnt  <= MC_INIT;
            mc_dst  <= mc_rd;
        end else if (mc_busy && mc_cnt != 4'd0) begin
            mc_cnt  <= mc_cnt - 4'd1;
        end else if (mc_busy) begin
            mc_busy <= 1'b0;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall && stall_cycles != CNT_MAX)
            stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the pipelined KGP-RISC core, superseding the fixed two-operand forwarding logic. It generates per-operand forward selects for the EX stage and load-use stall/bubble requests for ID. It adds a scoreboard for one multi-cycle execution unit (MUL/DIV), with result forwarding on its completion cycle and a saturating stall-cycle counter.

## Interface
- AW, 5: register address width.
- NSRC, 2: source operands per instruction (1..4).
- MC_LAT, 4: multi-cycle unit latency in cycles, issue to result (2..16).
- ZERO_REG, 1: when 1, register 0 is never matched for forwarding or stalls.
- CNT_W, 16: stall counter width.

- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_ex_src  in  NSRC*AW  source registers of the instruction in EX; operand i at [i*AW +: AW].
- ex_mem_rd, ex_mem_regwrite  in  AW, 1  EX/MEM destination and write enable.
- mem_wb_rd, mem_wb_regwrite  in  AW, 1  MEM/WB destination and write enable.
- if_id_src  in  NSRC*AW  source registers of the instruction in ID.
- if_id_valid, if_id_mc  in  1, 1  ID holds a real instruction / a multi-cycle op.
- id_ex_rd, id_ex_memread  in  AW, 1  EX destination; EX instruction is a load.
- mc_issue, mc_rd  in  1, AW  multi-cycle op leaving EX this cycle, its destination.
- fwd_sel  out  NSRC*2  per operand: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 MC result bus.
- stall  out  1  hold PC and IF/ID.
- flush_id_ex  out  1  insert bubble into ID/EX (equals stall).
- mc_done, mc_done_rd  out  1, AW  MC result valid this cycle (writeback), its destination.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

## Operation
- State: mc_busy, mc_cnt (4 bits), mc_dst (AW), stall_cycles.
- A register r is matchable when its write enable is 1 and (ZERO_REG=0 or r≠0).
- fwd_sel[i] priority: EX/MEM match → 10; else mc_done and mc_dst match → 11; else MEM/WB match → 01; else 00.
- Load-use hazard: if_id_valid & id_ex_memread & id_ex_rd matchable & id_ex_rd equals any if_id_src.
- MC RAW hazard: if_id_valid & any if_id_src equals a matchable register, with either (mc_busy & mc_cnt≥2 & register = mc_dst) or (mc_issue & register = mc_rd).
- MC structural hazard: if_id_valid & if_id_mc & ((mc_busy & mc_cnt≥2) | mc_issue).
- stall = OR of the three hazards. flush_id_ex = stall.
- Scoreboard, per clock edge:
  - mc_issue loads mc_cnt=MC_LAT-1, mc_dst=mc_rd, and sets mc_busy.
  - Otherwise, if mc_busy and mc_cnt≠0, mc_cnt decrements.
  - Otherwise, if mc_busy and mc_cnt=0, mc_busy clears.
- mc_done = mc_busy & mc_cnt=0. mc_done_rd = mc_dst.
- Issue on the mc_done cycle is legal; the new issue wins and mc_busy stays 1.
- An mc_issue while mc_busy and mc_cnt≠0 is a protocol violation. It cannot occur when stall is honoured. The block still applies load semantics.
- stall_cycles increments when stall=1 and holds at 2^CNT_W-1.

## Timing
- fwd_sel, stall, flush_id_ex and mc_done are combinational from inputs and state. No added latency.
- Dependent instruction timing: it leaves ID in the cycle mc_cnt=1 and sits in EX on the mc_done cycle, taking fwd_sel=11.
- MC_LAT=2: one stall cycle (issue cycle), then the consumer is in EX at done.
- Load-use costs exactly one stall cycle. The bubble clears id_ex_memread on the next cycle.
- Reset (asynchronous, any cycle), in effect immediately:
  - mc_busy=0, mc_cnt=0, mc_dst=0, stall_cycles=0.
  - stall=0, flush_id_ex=0, mc_done=0, mc_done_rd=0.
  - fwd_sel follows inputs.
  - An in-flight MC op is abandoned with no done pulse.
- rst deassertion is synchronised externally; the first edge after release may accept mc_issue.

## Test plan
- EX/MEM and MEM/WB both write r5, id_ex_src operand0=r5 → fwd_sel[1:0]=10. Drop ex_mem_regwrite → 01. Use r0 with ZERO_REG=1 → 00.
- Load to r3 in EX, ID reads r3 in operand1 → stall=flush_id_ex=1 for one cycle, stall_cycles 0→1. Next cycle (bubble) → stall=0.
- MC_LAT=4, mc_issue rd=r7 at t, ID reads r7 → stall at t, t+1, t+2 and none at t+3. mc_done=1, mc_done_rd=7 at t+4, consumer in EX gets fwd_sel=11.
- MC busy, EX/MEM also writes r7 on the done cycle → fwd_sel=10 (priority). Second MC op in ID → stalls until mc_cnt=1, issues on the done cycle, mc_busy stays 1.
- Assert rst at t+2 of an MC op → stall=0 and mc_done never pulses. stall_cycles=0. CNT_W=2 with 5 stall cycles → saturates at 3.
